dff_share_arbiter: RTL and testbench

//   Round-robin write arbiter for one shared WIDTH-bit D flip-flop register.
//   Up to NREQ requesters each present data and a request. The block grants one

---
 rtl/dff_share_arbiter.sv | 135 +++++++++++++
 tb/tb_dff_share_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_share_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register.
// Optional owner locking is compiled in with `define ARB_LOCK_EN.
module dff_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    d_in,
    input  logic [NREQ-1:0]          lock,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid
);

    localparam int OW = $clog2(NREQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [NREQ-1:0]   gnt_nx;
    logic [OW-1:0]     owner_nx;
    logic [OW-1:0]     ptr, ptr_nx;
    logic [WIDTH-1:0]  q_nx;
    logic              q_valid_nx;
    logic [OW-1:0]     winner;
    logic [OW-1:0]     idx;
    logic [WIDTH-1:0]  d_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign d_arr[i] = d_in[i*WIDTH +: WIDTH];
    end

`ifdef ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0] lock_cnt, lock_cnt_nx;
`else
    localparam int LOCK_MAX_UNUSED = LOCK_MAX;
    logic [NREQ-1:0] lock_unused;
    assign lock_unused = lock;
`endif

    // Scan downward from the farthest offset so the requester closest to ptr wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = OW'((int'(ptr) + i) % NREQ);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        owner_nx   = owner;
        ptr_nx     = ptr;
        q_nx       = q;
        q_valid_nx = 1'b0;
`ifdef ARB_LOCK_EN
        lock_cnt_nx = lock_cnt;
`endif
        case (state)
            IDLE: begin
                gnt_nx = '0;
                if (|req) begin
                    gnt_nx   = NREQ'(1) << winner;
                    owner_nx = winner;
                    state_nx = GRANT;
`ifdef ARB_LOCK_EN
                    if (winner != owner) begin
                        lock_cnt_nx = CW'(1);
                    end else if (lock_cnt != CW'(LOCK_MAX)) begin
                        lock_cnt_nx = lock_cnt + CW'(1);
                    end
`endif
                end
            end
            GRANT: begin
                q_nx       = d_arr[owner];
                q_valid_nx = 1'b1;
                gnt_nx     = '0;
                state_nx   = IDLE;
                ptr_nx     = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
`ifdef ARB_LOCK_EN
                // A still-requesting locked owner keeps the pointer until its quota runs out.
                if (lock[owner] && req[owner] && (lock_cnt < CW'(LOCK_MAX))) begin
                    ptr_nx = owner;
                end
`endif
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            owner   <= '0;
            ptr     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            gnt     <= gnt_nx;
            owner   <= owner_nx;
            ptr     <= ptr_nx;
            q       <= q_nx;
            q_valid <= q_valid_nx;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt_nx;
        end
    end
`endif

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed and randomized bench for dff_share_arbiter against a transaction-level model.
// Follows ARB_LOCK_EN the same way as the design.
module tb_dff_share_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  lock = '0;
    logic [31:0] d_in = '0;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic        q_valid;

    int compared = 0;
    int mismatched = 0;

    // Model: one write transaction = pick a winner, then deliver its data a cycle later.
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_run;
    logic [3:0] m_gnt;
    logic [7:0] m_q;
    logic       m_qv;

    int         g_log[$];
    logic [7:0] q_log[$];

    dff_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .d_in(d_in), .lock(lock),
        .gnt(gnt), .owner(owner), .q(q), .q_valid(q_valid)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d);
        req  = r;
        lock = l;
        d_in = d;
    endtask

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_run   = 0;
        m_gnt   = '0;
        m_q     = '0;
        m_qv    = 1'b0;
    endfunction

    function automatic void model_step();
        int  w;
        bit  hold;
        if (!m_busy) begin
            m_qv = 1'b0;
            m_gnt = '0;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            if (w >= 0) begin
                m_run   = (w == m_owner) ? m_run + 1 : 1;
                m_owner = w;
                m_gnt   = 4'(1 << w);
                m_busy  = 1'b1;
            end
        end else begin
            m_q    = d_in[m_owner*8 +: 8];
            m_qv   = 1'b1;
            m_gnt  = '0;
            m_busy = 1'b0;
            hold   = 1'b0;
`ifdef ARB_LOCK_EN
            hold = lock[m_owner] && req[m_owner] && (m_run < LOCK_MAX);
`endif
            m_ptr = hold ? m_owner : (m_owner + 1) % NREQ;
        end
    endfunction

    task automatic tick(input string tag);
        if (rst_n) model_step();
        else model_reset();
        @(posedge clk);
        #1;
        check_output({tag, ".gnt"}, 32'(gnt), 32'(m_gnt));
        check_output({tag, ".owner"}, 32'(owner), 32'(m_owner));
        check_output({tag, ".q"}, 32'(q), 32'(m_q));
        check_output({tag, ".q_valid"}, 32'(q_valid), 32'(m_qv));
        if (|gnt) g_log.push_back(int'(owner));
        if (q_valid) q_log.push_back(q);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("rst.gnt", 32'(gnt), 32'h0);
        check_output("rst.q", 32'(q), 32'h0);
        repeat (2) tick("rst");
        @(negedge clk);
        rst_n = 1'b1;
        g_log.delete();
        q_log.delete();
    endtask

    initial begin
        int exp_g[6];
        logic [7:0] exp_q[5];

        model_reset();
        $display("[TB] start");

        // 1: reset with all requests asserted
        apply_stimulus(4'hF, 4'h0, 32'h1312_1110);
        repeat (3) tick("t1");
        check_output("t1.owner", 32'(owner), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(4'h0, 4'h0, 32'h0);
        check_output("t1.gnt_after_release", 32'(gnt), 32'h0);

        // 2: single requester
        g_log.delete();
        q_log.delete();
        apply_stimulus(4'b0100, 4'h0, 32'h00A5_0000);
        tick("t2a");
        check_output("t2.gnt", 32'(gnt), 32'h4);
        apply_stimulus(4'b0000, 4'h0, 32'h00A5_0000);
        tick("t2b");
        check_output("t2.q", 32'(q), 32'hA5);
        check_output("t2.q_valid", 32'(q_valid), 32'h1);
        check_output("t2.owner", 32'(owner), 32'h2);
        tick("t2c");
        check_output("t2.q_valid_drop", 32'(q_valid), 32'h0);
        check_output("t2.q_hold", 32'(q), 32'hA5);

        // 4: wrap-around from ptr=3
        g_log.delete();
        apply_stimulus(4'b1001, 4'h0, 32'h4433_2211);
        repeat (4) tick("t4");
        check_output("t4.ngrants", 32'(g_log.size()), 32'd2);
        if (g_log.size() == 2) begin
            check_output("t4.g0", 32'(g_log[0]), 32'd3);
            check_output("t4.g1", 32'(g_log[1]), 32'd0);
        end

        // 3: all requesting from a fresh pointer
        do_reset();
        apply_stimulus(4'hF, 4'h0, 32'h1312_1110);
        repeat (10) tick("t3");
        exp_g = '{0, 1, 2, 3, 0, 0};
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        check_output("t3.ngrants", 32'(g_log.size()), 32'd5);
        check_output("t3.nwrites", 32'(q_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < g_log.size()) check_output($sformatf("t3.g%0d", i), 32'(g_log[i]), 32'(exp_g[i]));
            if (i < q_log.size()) check_output($sformatf("t3.q%0d", i), 32'(q_log[i]), 32'(exp_q[i]));
        end

        // 5: reset in the middle of a grant
        do_reset();
        apply_stimulus(4'b0010, 4'h0, 32'h0000_7700);
        tick("t5a");
        check_output("t5.gnt", 32'(gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("t5.q", 32'(q), 32'h0);
        check_output("t5.q_valid", 32'(q_valid), 32'h0);
        check_output("t5.gnt_rst", 32'(gnt), 32'h0);
        tick("t5b");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(4'b1010, 4'h0, 32'h0000_7700);
        tick("t5c");
        check_output("t5.first_owner", 32'(owner), 32'h1);
        tick("t5d");

        // 6: locked owner against a second requester
        do_reset();
        apply_stimulus(4'b0011, 4'b0001, 32'h0000_B1A0);
        repeat (12) tick("t6");
`ifdef ARB_LOCK_EN
        exp_g = '{0, 0, 0, 0, 1, 0};
`else
        exp_g = '{0, 1, 0, 1, 0, 1};
`endif
        check_output("t6.ngrants", 32'(g_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < g_log.size()) check_output($sformatf("t6.g%0d", i), 32'(g_log[i]), 32'(exp_g[i]));
        end

        // Randomized traffic, with occasional idle gaps and lock changes
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            apply_stimulus(r, 4'($urandom), $urandom);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
